clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable clock divider. Generates a divided clock-enable waveform with programmable period and high time from the 50 MHz system clock.
- Generalises the fixed 50 MHz -> 2 kHz divider. Divisor and duty are loaded through a valid/ready config port and applied glitch-free at period boundaries.
- A one-cycle period-start tick is also provided. Feeds the configurable modulator's carrier/symbol timing logic.

Parameters:
- WIDTH, 24, width of counter, divisor and high-time fields.
- DEFAULT_DIV, 25000, period in clk cycles after reset (2 kHz at 50 MHz).
- DEFAULT_HIGH, 12500, high time in clk cycles after reset (50% duty).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  run enable; 0 holds the divider idle.
- cfg_valid  input  1  config request.
- cfg_div  input  WIDTH  requested period in cycles.
- cfg_high  input  WIDTH  requested high time in cycles.
- cfg_ready  output  1  config port can accept.
- cfg_err  output  1  one-cycle pulse: last accepted config rejected.
- clk_out  output  1  divided waveform (registered).
- tick  output  1  one-cycle pulse on the first cycle of each period (registered).

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-period included):
  - state=IDLE, cnt=0, div_act=DEFAULT_DIV, high_act=DEFAULT_HIGH, pending=0.
  - clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
  - rst overrides en and cfg_valid in the same cycle.
- Active values are valid when 2 <= div <= 2^WIDTH-1 and 1 <= high <= div-1.
  - Compare at WIDTH bits, unsigned. No wrap arithmetic on the divisor.
- States:
  - IDLE: cnt=0, clk_out=0, tick=0. If en=1, next state is RUN; that edge loads cnt<=0, clk_out<=1, tick<=1. The first RUN cycle is a period start.
  - RUN, each edge with en=1:
    - If cnt==div_act-1 (terminal), cnt<=0 and any pending config is copied into div_act/high_act. Otherwise cnt<=cnt+1.
    - clk_out <= (next_cnt < next_high_act).
    - tick <= (next_cnt==0).
  - RUN to IDLE: en=0 at an edge gives clk_out<=0, tick<=0, cnt<=0 immediately, without waiting for the period end.
- Output pattern: clk_out is high for exactly high_act cycles, then low for div_act-high_act cycles. Period is exactly div_act cycles; tick fires once per period, coincident with the first high cycle.
- Config handshake:
  - cfg_ready = ~pending. A transfer occurs on an edge with cfg_valid & cfg_ready.
  - Invalid values: nothing stored, cfg_err=1 for the next cycle only, pending unchanged.
  - Valid values: stored into shadow registers, pending<=1, cfg_ready drops next cycle.
  - In IDLE, pending is applied on the next edge and cleared, so ready returns after 1 cycle.
  - In RUN, pending is applied on the terminal edge and cleared at that edge.
  - Accept on the terminal edge itself: the accepted values bypass the shadow and take effect for the period starting at that edge; pending stays 0.
  - cfg_valid while cfg_ready=0: ignored. The requester must hold its values until accepted.
- Active values never change mid-period: no runt or stretched pulses, except when leaving RUN via en=0 or rst.
- Latency:
  - en high to first tick/clk_out high: 1 edge.
  - Config accept to effect in RUN: 1 to div_act cycles.
- Counter width is WIDTH. cnt never exceeds div_act-1, so no overflow.

Test Plan:
- Reset default: rst, then en=1 for 60000 cycles -> clk_out period 25000, high 12500 cycles, tick every 25000 cycles coincident with the rising clk_out, first tick 1 cycle after en.
- Small config in IDLE: cfg_div=5, cfg_high=2 with en=0, then en=1 -> clk_out pattern 1,1,0,0,0 repeating; tick on each first '1'; cfg_ready back high 1 cycle after accept.
- Mid-period reconfig: running div=5/high=2, at cnt=1 load div=4/high=3 -> current period completes as 11000, next periods 1110; cfg_ready low until the terminal edge; a second cfg_valid while low is ignored.
- Invalid configs: div=1; high=0; high=div=6 -> cfg_err single-cycle pulse each, active period unchanged, cfg_ready stays 1.
- Terminal-edge accept: load div=3/high=1 exactly on the cnt==div_act-1 edge -> next period already 100, no pending, cfg_ready stays 1.
- Disruption: en=0 at cnt=2 of a div=5 period -> clk_out/tick 0 next cycle. rst mid-period with pending config -> defaults restored, pending discarded, first period after en is 25000/12500.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider.
// Produces a registered divided waveform (clk_out) and a one-cycle
// period-start tick. Period and high time come in through a valid/ready
// config port. New values only take effect at a period boundary, so the
// output never has a runt or stretched pulse while running.
`timescale 1ns/1ps

module clk_div_prog #(
  parameter int          WIDTH        = 24,
  parameter int unsigned DEFAULT_DIV  = 25000,
  parameter int unsigned DEFAULT_HIGH = 12500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] high_act;
  logic [WIDTH-1:0] div_sh;
  logic [WIDTH-1:0] high_sh;
  logic             pending;

  logic             cfg_ok;
  logic             xfer;
  logic             terminal;
  logic             bypass;
  logic             apply_shadow;
  logic             store_shadow;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] next_high;

  // A new request can only be taken while no config is waiting.
  assign cfg_ready = ~pending;

  // Decode the handshake and work out the counter and active values after this edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    cfg_ok       = 1'b0;
    xfer         = 1'b0;
    terminal     = 1'b0;
    bypass       = 1'b0;
    apply_shadow = 1'b0;
    store_shadow = 1'b0;
    next_cnt     = '0;
    next_div     = div_act;
    next_high    = high_act;

    // div is always <= 2^WIDTH-1 by construction; high < div keeps high <= div-1 without subtracting.
    cfg_ok   = (cfg_div >= WIDTH'(2)) && (cfg_high != '0) && (cfg_high < cfg_div);
    xfer     = cfg_valid && !pending;
    terminal = (cnt == div_act - WIDTH'(1));

    // Accepting on the terminal edge goes straight to the active set for the new period.
    bypass       = (state == RUN) && en && terminal && xfer && cfg_ok;
    // In IDLE there is no period to protect, so a waiting config is applied at once.
    apply_shadow = pending && ((state == IDLE) || (en && terminal));
    store_shadow = xfer && cfg_ok && !bypass;

    if (bypass) begin
      next_div  = cfg_div;
      next_high = cfg_high;
    end else if (apply_shadow) begin
      next_div  = div_sh;
      next_high = high_sh;
    end

    if ((state == RUN) && !terminal) begin
      next_cnt = cnt + WIDTH'(1);
    end
  end

  // Divider state machine, active/shadow config registers and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_act  <= WIDTH'(DEFAULT_DIV);
      high_act <= WIDTH'(DEFAULT_HIGH);
      div_sh   <= '0;
      high_sh  <= '0;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err  <= xfer && !cfg_ok;
      div_act  <= next_div;
      high_act <= next_high;

      if (store_shadow) begin
        div_sh  <= cfg_div;
        high_sh <= cfg_high;
        pending <= 1'b1;
      end else if (apply_shadow) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state   <= RUN;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end else begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end else begin
            cnt     <= next_cnt;
            clk_out <= (next_cnt < next_high);
            tick    <= (next_cnt == '0);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: a cycle-level reference model pushes the
// expected {clk_out, tick, cfg_ready, cfg_err} for every driven cycle into
// a scoreboard queue; the entry is popped and compared half a cycle after
// the edge. Directed constant checks cover the documented waveforms.
`timescale 1ns/1ps

module tb_clk_div_prog;

  localparam int W = 24;

  typedef struct packed {
    logic clk_o;
    logic tick_o;
    logic ready_o;
    logic err_o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         tick;

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [15:0] hist = '0;

  // Reference model state.
  bit          m_run;
  int unsigned m_phase;
  int unsigned m_div;
  int unsigned m_high;
  int unsigned m_sdiv;
  int unsigned m_shigh;
  bit          m_pend;
  bit          m_clk;
  bit          m_tick;
  bit          m_err;

  clk_div_prog #(
    .WIDTH        (W),
    .DEFAULT_DIV  (25000),
    .DEFAULT_HIGH (12500)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after one clock edge, given the inputs presented to it.
  task automatic model(input logic r, input logic e, input logic v,
                       input logic [W-1:0] d, input logic [W-1:0] h);
    bit take;
    bit ok;
    if (r) begin
      m_run = 0; m_phase = 0; m_div = 25000; m_high = 12500;
      m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;
    end else begin
      take  = v && !m_pend;
      ok    = (d >= 2) && (h >= 1) && (h < d);
      m_err = take && !ok;
      if (!m_run) begin
        if (m_pend) begin
          m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
        end else if (take && ok) begin
          m_sdiv = d; m_shigh = h; m_pend = 1;
        end
        m_run = e; m_phase = 0; m_clk = e; m_tick = e;
      end else if (!e) begin
        if (take && ok) begin
          m_sdiv = d; m_shigh = h; m_pend = 1;
        end
        m_run = 0; m_phase = 0; m_clk = 0; m_tick = 0;
      end else begin
        if (m_phase == m_div - 1) begin
          m_phase = 0;
          if (take && ok) begin
            m_div = d; m_high = h;
          end else if (m_pend) begin
            m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
          end
        end else begin
          m_phase++;
          if (take && ok) begin
            m_sdiv = d; m_shigh = h; m_pend = 1;
          end
        end
        m_clk  = (m_phase < m_high);
        m_tick = (m_phase == 0);
      end
    end
    sb.push_back('{clk_o: m_clk, tick_o: m_tick, ready_o: !m_pend, err_o: m_err});
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the scoreboard head.
  task automatic cycle(input logic r, input logic e, input logic v,
                       input logic [W-1:0] d, input logic [W-1:0] h);
    rst = r; en = e; cfg_valid = v; cfg_div = d; cfg_high = h;
    model(r, e, v, d, h);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp_t x;
      x = sb.pop_front();
      check("cyc", {28'd0, clk_out, tick, cfg_ready, cfg_err}, {28'd0, x});
    end
    hist = {hist[14:0], clk_out};
  endtask

  initial begin
    int tick_idx[$];
    int highs;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;

    // Reset and default 25000/12500 waveform.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_err", cfg_err, 0);
    highs = 0;
    for (int i = 0; i < 60000; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (tick) tick_idx.push_back(i);
      if (clk_out) highs++;
    end
    check("def_ntick", tick_idx.size(), 3);
    check("def_tick0", (tick_idx.size() > 0) ? tick_idx[0] : -1, 0);
    check("def_tick1", (tick_idx.size() > 1) ? tick_idx[1] : -1, 25000);
    check("def_tick2", (tick_idx.size() > 2) ? tick_idx[2] : -1, 50000);
    check("def_highs", highs, 35000);

    // Small config loaded in IDLE, then run.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 5, 2);
    check("idle_acc_ready", cfg_ready, 0);
    cycle(0, 0, 0, 0, 0);
    check("idle_ready_back", cfg_ready, 1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0);
    check("pat_5_2", hist[11:0], 12'b110001100011);

    // Mid-period reconfig at cnt=1; a second request while not ready is ignored.
    cycle(0, 1, 1, 4, 3);
    check("mid_ready_low", cfg_ready, 0);
    cycle(0, 1, 1, 7, 1);
    cycle(0, 1, 1, 7, 1);
    check("mid_ready_still_low", cfg_ready, 0);
    cycle(0, 1, 1, 7, 1);
    check("mid_ready_after_term", cfg_ready, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
    check("pat_reconf", hist[11:0], 12'b000111011101);

    // Invalid configs: div=1, high=0, high=div.
    cycle(0, 1, 1, 1, 1);
    check("err_div1", cfg_err, 1);
    check("err_div1_ready", cfg_ready, 1);
    cycle(0, 1, 0, 0, 0);
    check("err_div1_clear", cfg_err, 0);
    cycle(0, 1, 1, 6, 0);
    check("err_high0", cfg_err, 1);
    cycle(0, 1, 0, 0, 0);
    check("err_high0_clear", cfg_err, 0);
    cycle(0, 1, 1, 6, 6);
    check("err_higheq", cfg_err, 1);
    check("err_higheq_ready", cfg_ready, 1);
    cycle(0, 1, 0, 0, 0);
    check("err_higheq_clear", cfg_err, 0);
    check("pat_invalid", hist[5:0], 6'b110111);

    // Accept exactly on the terminal edge (cnt=3 of div=4).
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 3, 1);
    check("term_ready", cfg_ready, 1);
    check("term_tick", tick, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
    check("pat_term", hist[6:0], 7'b0100100);

    // Switch to div=5/high=2 on a terminal edge, then drop en at cnt=2.
    cycle(0, 1, 1, 5, 2);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("en_off_clk", clk_out, 0);
    check("en_off_tick", tick, 0);
    check("pat_en_off", hist[3:0], 4'b1100);

    // Reset mid-period with a pending config; rst also overrides en and cfg_valid.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 9, 4);
    check("pend_ready_low", cfg_ready, 0);
    cycle(1, 1, 1, 3, 1);
    check("rst2_ready", cfg_ready, 1);
    check("rst2_clk", clk_out, 0);
    check("rst2_tick", tick, 0);
    check("rst2_err", cfg_err, 0);
    tick_idx.delete();
    highs = 0;
    for (int i = 0; i < 25001; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (tick) tick_idx.push_back(i);
      if (clk_out) highs++;
    end
    check("rst2_ntick", tick_idx.size(), 2);
    check("rst2_tick0", (tick_idx.size() > 0) ? tick_idx[0] : -1, 0);
    check("rst2_tick1", (tick_idx.size() > 1) ? tick_idx[1] : -1, 25000);
    check("rst2_highs", highs, 12501);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
